// File: rtl/pipe_cu.sv
// ---------------------------------------------------------------------------
// pipe_cu : pipelined RV32 control unit.
//
// The ID stage decodes opcode/funct3/funct7 into a control bundle. The bundle
// then moves through three registers: ID/EX, EX/MEM and MEM/WB. EX resolves
// branches and jumps, and PCSrc drives the flush of the younger instructions.
// Illegal encodings are tagged in ID, and a saturating counter counts them in EX.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   id_valid        ID holds a real instruction (0 = bubble)
//   opcode/funct3/funct7  ID instruction fields ([6:0], [14:12], bit 30)
//   stall           load-use stall from the hazard unit; bubbles ID/EX
//   zeroFlag/signFlag  EX ALU result flags
//   id_ImmSrc       immediate format (00 I, 01 S, 10 B, 11 J), combinational
//   id_illegal      ID holds a valid but unsupported encoding, combinational
//   ex_ALUControl   ALU op, zero-extended to ALUCTRL_W
//   ex_ALUSrc       1 = immediate operand
//   PCSrc, flush_d  take the branch/jump target; flush IF/ID
//   mem_*           EX/MEM controls (for forwarding and the memory stage)
//   wb_*            MEM/WB controls (00 ALU, 01 memory, 10 PC+4)
//   illegal_cnt     saturating count of illegal instructions seen in EX
// ---------------------------------------------------------------------------
module pipe_cu #(
   parameter int ALUCTRL_W = 3,   // must be >= 3
   parameter int ILLCNT_W  = 8,
   parameter bit EN_BGE    = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 id_valid,
   input  logic [6:0]           opcode,
   input  logic [2:0]           funct3,
   input  logic                 funct7,
   input  logic                 stall,
   input  logic                 zeroFlag,
   input  logic                 signFlag,
   output logic [1:0]           id_ImmSrc,
   output logic                 id_illegal,
   output logic [ALUCTRL_W-1:0] ex_ALUControl,
   output logic                 ex_ALUSrc,
   output logic                 PCSrc,
   output logic                 flush_d,
   output logic                 mem_MemWrite,
   output logic                 mem_RegWrite,
   output logic [1:0]           mem_ResultSrc,
   output logic                 wb_RegWrite,
   output logic [1:0]           wb_ResultSrc,
   output logic [ILLCNT_W-1:0]  illegal_cnt
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic [1:0] {BR_EQ, BR_NE, BR_LT, BR_GE} br_e;

   typedef struct packed {
      logic       reg_write;
      logic       mem_write;
      logic       alu_src;
      logic [1:0] result_src;
      logic [2:0] alu;
      logic       branch;
      logic       jump;
      br_e        br_type;
      logic       illegal;
   } ctrl_t;

   ctrl_t               dec;
   ctrl_t               idex_d, idex_q;
   logic [1:0]          imm_src;
   logic                unsupported;
   logic                br_cond;
   logic                pc_src;

   logic                exmem_mem_write_q, exmem_reg_write_q;
   logic [1:0]          exmem_result_src_q;
   logic                memwb_reg_write_q;
   logic [1:0]          memwb_result_src_q;
   logic [ILLCNT_W-1:0] illcnt_q, illcnt_d;

   // ---------------- ID decode ----------------
   always_comb begin
      dec         = '0;
      imm_src     = 2'b00;
      unsupported = 1'b0;
      case (opcode)
         OP_LOAD: begin
            dec.result_src = 2'b01;
            dec.alu_src    = 1'b1;
            dec.reg_write  = 1'b1;
         end
         OP_STORE: begin
            dec.mem_write = 1'b1;
            dec.alu_src   = 1'b1;
            imm_src       = 2'b01;
         end
         OP_R: begin
            dec.reg_write = 1'b1;
            dec.alu       = funct3;
            if (funct3 == 3'b000 && funct7)
               dec.alu = 3'b010;                       // SUB
            if (funct3 == 3'b010 || funct3 == 3'b011)
               unsupported = 1'b1;
         end
         OP_I: begin
            // There is no SUBI, so funct7 does not change the add.
            dec.reg_write = 1'b1;
            dec.alu_src   = 1'b1;
            dec.alu       = funct3;
            if (funct3 == 3'b010 || funct3 == 3'b011)
               unsupported = 1'b1;
         end
         OP_BRANCH: begin
            dec.branch = 1'b1;
            dec.alu    = 3'b010;                       // compare via SUB
            imm_src    = 2'b10;
            case (funct3)
               3'b000:  dec.br_type = BR_EQ;
               3'b001:  dec.br_type = BR_NE;
               3'b100:  dec.br_type = BR_LT;
               3'b101: begin
                  if (EN_BGE) dec.br_type = BR_GE;
                  else        unsupported = 1'b1;
               end
               default: unsupported = 1'b1;
            endcase
         end
         OP_JAL: begin
            dec.jump       = 1'b1;
            dec.reg_write  = 1'b1;
            dec.result_src = 2'b10;
            imm_src        = 2'b11;
         end
         default: unsupported = 1'b1;
      endcase

      // Bubbles and illegal encodings carry no side effects. Only the tag
      // survives, so that EX can count it.
      if (!id_valid || unsupported) begin
         dec     = '0;
         imm_src = 2'b00;
      end
      dec.illegal = id_valid & unsupported;
   end

   assign id_ImmSrc  = imm_src;
   assign id_illegal = dec.illegal;

   // ---------------- ID/EX ----------------
   // A taken branch/jump in EX squashes the instruction behind it. A stall
   // inserts a bubble while the hazard unit holds ID.
   assign idex_d = (stall || pc_src) ? '0 : dec;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) idex_q <= '0;
      else     idex_q <= idex_d;
   end

   // ---------------- EX resolve ----------------
   always_comb begin
      br_cond = 1'b0;
      case (idex_q.br_type)
         BR_EQ: br_cond =  zeroFlag;
         BR_NE: br_cond = ~zeroFlag;
         BR_LT: br_cond =  signFlag;
         BR_GE: br_cond = ~signFlag;
         default: br_cond = 1'b0;
      endcase
      pc_src = idex_q.jump | (idex_q.branch & br_cond);
   end

   assign PCSrc         = pc_src;
   assign flush_d       = pc_src;
   assign ex_ALUControl = ALUCTRL_W'(idex_q.alu);
   assign ex_ALUSrc     = idex_q.alu_src;

   // ---------------- EX/MEM, MEM/WB (never held) ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exmem_mem_write_q  <= 1'b0;
         exmem_reg_write_q  <= 1'b0;
         exmem_result_src_q <= 2'b00;
         memwb_reg_write_q  <= 1'b0;
         memwb_result_src_q <= 2'b00;
      end else begin
         exmem_mem_write_q  <= idex_q.mem_write;
         exmem_reg_write_q  <= idex_q.reg_write;
         exmem_result_src_q <= idex_q.result_src;
         memwb_reg_write_q  <= exmem_reg_write_q;
         memwb_result_src_q <= exmem_result_src_q;
      end
   end

   assign mem_MemWrite  = exmem_mem_write_q;
   assign mem_RegWrite  = exmem_reg_write_q;
   assign mem_ResultSrc = exmem_result_src_q;
   assign wb_RegWrite   = memwb_reg_write_q;
   assign wb_ResultSrc  = memwb_result_src_q;

   // ---------------- illegal counter ----------------
   always_comb begin
      illcnt_d = illcnt_q;
      if (idex_q.illegal && !(&illcnt_q))
         illcnt_d = illcnt_q + ILLCNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) illcnt_q <= '0;
      else     illcnt_q <= illcnt_d;
   end

   assign illegal_cnt = illcnt_q;

endmodule
